// File: rtl/sonic_address_converter_mc_if.sv
// Request, output, release and status bundle for sonic_address_converter_mc.
// The converter uses the slave modport; the driving DMA side uses the master modport.
interface sonic_address_converter_mc_if #(
  parameter int ADDR_W     = 13,
  parameter int NUM_CH     = 2,
  parameter int RING_WORDS = 3000,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PHYS_W     = $clog2(NUM_CH * RING_WORDS),
  parameter int LVL_W      = $clog2(RING_WORDS + 1)
) ();

  logic [NUM_CH-1:0]       cfg_mode_in;
  logic                    req_valid_in;
  logic                    req_ready_out;
  logic [CH_W-1:0]         req_ch_in;
  logic [ADDR_W-1:0]       req_addr_in;
  logic                    out_valid_out;
  logic                    out_ready_in;
  logic [CH_W-1:0]         out_ch_out;
  logic [PHYS_W-1:0]       out_addr_out;
  logic                    out_wrap_out;
  logic                    rel_valid_in;
  logic [CH_W-1:0]         rel_ch_in;
  logic [ADDR_W-1:0]       rel_count_in;
  logic [NUM_CH*LVL_W-1:0] level_out;
  logic [NUM_CH-1:0]       full_out;
  logic [NUM_CH-1:0]       empty_out;
  logic [NUM_CH-1:0]       err_out;

  modport slave (
    input  cfg_mode_in, req_valid_in, req_ch_in, req_addr_in,
    input  out_ready_in, rel_valid_in, rel_ch_in, rel_count_in,
    output req_ready_out, out_valid_out, out_ch_out, out_addr_out, out_wrap_out,
    output level_out, full_out, empty_out, err_out
  );

  modport master (
    output cfg_mode_in, req_valid_in, req_ch_in, req_addr_in,
    output out_ready_in, rel_valid_in, rel_ch_in, rel_count_in,
    input  req_ready_out, out_valid_out, out_ch_out, out_addr_out, out_wrap_out,
    input  level_out, full_out, empty_out, err_out
  );

endinterface

// File: rtl/sonic_address_converter_mc.sv
// Multi-channel ring address converter: maps per-channel word requests (direct offset or
// auto-incrementing stream pointer) to physical buffer RAM addresses, with fill tracking.
module sonic_address_converter_mc #(
  parameter int ADDR_W     = 13,
  parameter int NUM_CH     = 2,
  parameter int RING_WORDS = 3000,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int PHYS_W     = $clog2(NUM_CH * RING_WORDS),
  parameter int LVL_W      = $clog2(RING_WORDS + 1)
) (
  input logic                  clk_in,
  input logic                  rst_in,
  sonic_address_converter_mc_if.slave bus
);

  localparam int SUM_W = ((ADDR_W > LVL_W) ? ADDR_W : LVL_W) + 1;
  localparam logic [ADDR_W:0]    RING_A = (ADDR_W + 1)'(RING_WORDS);
  localparam logic [ADDR_W-1:0]  LAST_A = ADDR_W'(RING_WORDS - 1);
  localparam logic [LVL_W-1:0]   RING_L = LVL_W'(RING_WORDS);

  logic [ADDR_W-1:0] wptr_r      [NUM_CH];
  logic [LVL_W-1:0]  level_r     [NUM_CH];
  logic [NUM_CH-1:0] full_r;
  logic [NUM_CH-1:0] empty_r;
  logic [NUM_CH-1:0] err_r;
  logic              out_valid_r;
  logic [CH_W-1:0]   out_ch_r;
  logic [PHYS_W-1:0] out_addr_r;
  logic              out_wrap_r;

  logic [NUM_CH-1:0] req_hit_s;
  logic              ch_ok_s;
  logic              sel_mode_s;
  logic              sel_full_s;
  logic [ADDR_W-1:0] sel_wptr_s;
  logic [PHYS_W-1:0] sel_base_s;
  logic              ready_s;
  logic              accept_s;
  logic              addr_bad_s;
  logic              load_s;
  logic [ADDR_W-1:0] local_s;

  logic [NUM_CH-1:0] acc_st_s;
  logic [NUM_CH-1:0] rel_hit_s;
  logic [NUM_CH-1:0] err_nxt_s;
  logic [SUM_W-1:0]  sum_s       [NUM_CH];
  logic [LVL_W-1:0]  level_nxt_s [NUM_CH];
  logic [ADDR_W-1:0] wptr_nxt_s  [NUM_CH];
  logic [NUM_CH*LVL_W-1:0] level_flat_s;

  // Decode the request channel into the selected channel's mode, full flag, pointer and ring base.
  always_comb begin
    req_hit_s  = '0;
    ch_ok_s    = 1'b0;
    sel_mode_s = 1'b0;
    sel_full_s = 1'b0;
    sel_wptr_s = '0;
    sel_base_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      req_hit_s[c] = (bus.req_ch_in == CH_W'(c));
      ch_ok_s      = ch_ok_s | req_hit_s[c];
      sel_mode_s   = sel_mode_s | (req_hit_s[c] & bus.cfg_mode_in[c]);
      sel_full_s   = sel_full_s | (req_hit_s[c] & full_r[c]);
      sel_wptr_s   = sel_wptr_s | ({ADDR_W{req_hit_s[c]}} & wptr_r[c]);
      sel_base_s   = sel_base_s | ({PHYS_W{req_hit_s[c]}} & PHYS_W'(c * RING_WORDS));
    end
  end

  // Accept decision; an unknown channel selects nothing so it is always accepted and dropped.
  always_comb begin
    ready_s    = !rst_in && (!out_valid_r || bus.out_ready_in) && !(sel_mode_s && sel_full_s);
    accept_s   = bus.req_valid_in && ready_s;
    local_s    = sel_mode_s ? sel_wptr_s : bus.req_addr_in;
    addr_bad_s = !sel_mode_s && ({1'b0, bus.req_addr_in} >= RING_A);
    load_s     = accept_s && ch_ok_s && !addr_bad_s;
  end

  // Per-channel pointer, level and error next state; accept and release combine in one step.
  always_comb begin
    acc_st_s  = '0;
    rel_hit_s = '0;
    err_nxt_s = err_r;
    for (int c = 0; c < NUM_CH; c++) begin
      sum_s[c]       = '0;
      level_nxt_s[c] = level_r[c];
      wptr_nxt_s[c]  = wptr_r[c];
    end
    for (int c = 0; c < NUM_CH; c++) begin
      acc_st_s[c]  = accept_s && req_hit_s[c] && bus.cfg_mode_in[c];
      rel_hit_s[c] = bus.rel_valid_in && (bus.rel_ch_in == CH_W'(c));
      err_nxt_s[c] = err_r[c] | (accept_s && req_hit_s[c] && addr_bad_s);
      sum_s[c]     = SUM_W'(level_r[c]) + SUM_W'(acc_st_s[c]);
      if (acc_st_s[c]) begin
        wptr_nxt_s[c] = (wptr_r[c] == LAST_A) ? '0 : wptr_r[c] + ADDR_W'(1);
      end else begin
        wptr_nxt_s[c] = wptr_r[c];
      end
      if (rel_hit_s[c]) begin
        if (SUM_W'(bus.rel_count_in) > sum_s[c]) begin
          // Underflow clamps rather than wrapping so the ring never looks spuriously full.
          level_nxt_s[c] = '0;
          err_nxt_s[c]   = 1'b1;
        end else begin
          level_nxt_s[c] = LVL_W'(sum_s[c] - SUM_W'(bus.rel_count_in));
        end
      end else begin
        level_nxt_s[c] = LVL_W'(sum_s[c]);
      end
    end
  end

  // Channel state and single-stage output register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_r[c]  <= '0;
        level_r[c] <= '0;
      end
      full_r      <= '0;
      empty_r     <= '1;
      err_r       <= '0;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_addr_r  <= '0;
      out_wrap_r  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr_r[c]  <= wptr_nxt_s[c];
        level_r[c] <= level_nxt_s[c];
        full_r[c]  <= (level_nxt_s[c] == RING_L);
        empty_r[c] <= (level_nxt_s[c] == '0);
      end
      err_r <= err_nxt_s;
      if (load_s) begin
        out_valid_r <= 1'b1;
        out_ch_r    <= bus.req_ch_in;
        out_addr_r  <= sel_base_s + PHYS_W'(local_s);
        out_wrap_r  <= (local_s == LAST_A);
      end else if (bus.out_ready_in) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  // Flatten per-channel levels onto the status bus.
  always_comb begin
    level_flat_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      level_flat_s[c*LVL_W +: LVL_W] = level_r[c];
    end
  end

  assign bus.req_ready_out = ready_s;
  assign bus.out_valid_out = out_valid_r;
  assign bus.out_ch_out    = out_ch_r;
  assign bus.out_addr_out  = out_addr_r;
  assign bus.out_wrap_out  = out_wrap_r;
  assign bus.level_out     = level_flat_s;
  assign bus.full_out      = full_r;
  assign bus.empty_out     = empty_r;
  assign bus.err_out       = err_r;

endmodule

// File: tb/tb_sonic_address_converter_mc.sv
// Directed bench for sonic_address_converter_mc at default parameters (2 channels x 3000 words).
module tb_sonic_address_converter_mc;

  localparam int ADDR_W = 13;
  localparam int NUM_CH = 2;
  localparam int RING   = 3000;
  localparam int LVL_W  = 12;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_in = ~clk_in;

  sonic_address_converter_mc_if #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .RING_WORDS(RING)) bus ();

  sonic_address_converter_mc #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .RING_WORDS(RING)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [31:0] lvl(input int ch);
    return 32'(bus.level_out[ch*LVL_W +: LVL_W]);
  endfunction

  task automatic req(input logic v, input logic ch, input logic [ADDR_W-1:0] a);
    bus.req_valid_in = v;
    bus.req_ch_in    = ch;
    bus.req_addr_in  = a;
  endtask

  task automatic rel(input logic v, input logic ch, input logic [ADDR_W-1:0] n);
    bus.rel_valid_in = v;
    bus.rel_ch_in    = ch;
    bus.rel_count_in = n;
  endtask

  initial begin
    int bad_addr;
    int bad_wrap;
    int bad_hold;
    bus.cfg_mode_in  = 2'b00;
    bus.out_ready_in = 1'b1;
    req(1'b0, 1'b0, 13'd0);
    rel(1'b0, 1'b0, 13'd0);

    // reset state
    tick();
    tick();
    check("ready_in_reset", 32'(bus.req_ready_out), 32'd0);
    rst_in = 1'b0;
    tick();
    check("rst_valid", 32'(bus.out_valid_out), 32'd0);
    check("rst_level", 32'(bus.level_out), 32'd0);
    check("rst_empty", 32'(bus.empty_out), 32'd3);
    check("rst_full", 32'(bus.full_out), 32'd0);
    check("rst_err", 32'(bus.err_out), 32'd0);
    check("ready_idle", 32'(bus.req_ready_out), 32'd1);

    // 1: direct ch1 offset 100
    req(1'b1, 1'b1, 13'd100);
    tick();
    req(1'b0, 1'b0, 13'd0);
    check("t1_valid", 32'(bus.out_valid_out), 32'd1);
    check("t1_ch", 32'(bus.out_ch_out), 32'd1);
    check("t1_addr", 32'(bus.out_addr_out), 32'd3100);
    check("t1_wrap", 32'(bus.out_wrap_out), 32'd0);
    check("t1_level1", lvl(1), 32'd0);
    tick();
    check("t1_drained", 32'(bus.out_valid_out), 32'd0);

    // 2: stream ch0 fills the ring
    bus.cfg_mode_in = 2'b01;
    bad_addr = 0;
    bad_wrap = 0;
    for (int i = 0; i < RING; i++) begin
      req(1'b1, 1'b0, 13'd0);
      tick();
      if (bus.out_addr_out !== 13'(i) || bus.out_valid_out !== 1'b1) bad_addr++;
      if (bus.out_wrap_out !== (i == RING - 1)) bad_wrap++;
    end
    check("t2_addr_seq", 32'(bad_addr), 32'd0);
    check("t2_wrap_seq", 32'(bad_wrap), 32'd0);
    check("t2_full0", 32'(bus.full_out[0]), 32'd1);
    check("t2_level0", lvl(0), 32'd3000);
    #1;
    check("t2_ready_full", 32'(bus.req_ready_out), 32'd0);
    req(1'b1, 1'b1, 13'd5);
    #1;
    check("t2_ready_ch1", 32'(bus.req_ready_out), 32'd1);
    tick();
    check("t2_ch1_addr", 32'(bus.out_addr_out), 32'd3005);
    req(1'b0, 1'b0, 13'd0);
    rel(1'b1, 1'b0, 13'd10);
    tick();
    rel(1'b0, 1'b0, 13'd0);
    check("t2_rel_level", lvl(0), 32'd2990);
    check("t2_rel_full", 32'(bus.full_out[0]), 32'd0);
    req(1'b1, 1'b0, 13'd0);
    tick();
    req(1'b0, 1'b0, 13'd0);
    check("t2_wrap_addr", 32'(bus.out_addr_out), 32'd0);
    check("t2_level_after", lvl(0), 32'd2991);
    tick();

    // 3: stream ch1 under backpressure
    bus.cfg_mode_in  = 2'b11;
    bus.out_ready_in = 1'b0;
    req(1'b1, 1'b1, 13'd0);
    tick();
    check("t3_first", 32'(bus.out_addr_out), 32'd3000);
    bad_hold = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.req_ready_out !== 1'b0) bad_hold++;
      tick();
      if (bus.out_addr_out !== 13'd3000 || bus.out_valid_out !== 1'b1) bad_hold++;
    end
    check("t3_hold", 32'(bad_hold), 32'd0);
    bus.out_ready_in = 1'b1;
    tick();
    check("t3_next1", 32'(bus.out_addr_out), 32'd3001);
    tick();
    check("t3_next2", 32'(bus.out_addr_out), 32'd3002);
    req(1'b0, 1'b0, 13'd0);
    tick();
    check("t3_level1", lvl(1), 32'd3);

    // 4: simultaneous accept and release, then underflow
    rel(1'b1, 1'b0, 13'd2986);
    tick();
    check("t4_level5", lvl(0), 32'd5);
    req(1'b1, 1'b0, 13'd0);
    rel(1'b1, 1'b0, 13'd3);
    tick();
    req(1'b0, 1'b0, 13'd0);
    check("t4_level3", lvl(0), 32'd3);
    check("t4_addr", 32'(bus.out_addr_out), 32'd1);
    rel(1'b1, 1'b0, 13'd10);
    tick();
    rel(1'b0, 1'b0, 13'd0);
    check("t4_under_level", lvl(0), 32'd0);
    check("t4_under_err", 32'(bus.err_out[0]), 32'd1);
    check("t4_under_empty", 32'(bus.empty_out[0]), 32'd1);

    // 5: direct out-of-range on ch1, then the last slot
    bus.cfg_mode_in = 2'b01;
    req(1'b1, 1'b1, 13'd3000);
    tick();
    req(1'b0, 1'b0, 13'd0);
    check("t5_drop_valid", 32'(bus.out_valid_out), 32'd0);
    check("t5_err", 32'(bus.err_out), 32'd3);
    tick();
    check("t5_err_sticky", 32'(bus.err_out[1]), 32'd1);
    req(1'b1, 1'b1, 13'd2999);
    tick();
    req(1'b0, 1'b0, 13'd0);
    check("t5_last_addr", 32'(bus.out_addr_out), 32'd5999);
    check("t5_last_wrap", 32'(bus.out_wrap_out), 32'd1);
    check("t5_level1", lvl(1), 32'd3);

    // 6: reset mid-stream
    req(1'b1, 1'b0, 13'd0);
    for (int i = 0; i < 7; i++) tick();
    req(1'b0, 1'b0, 13'd0);
    check("t6_level7", lvl(0), 32'd7);
    check("t6_valid", 32'(bus.out_valid_out), 32'd1);
    rst_in = 1'b1;
    tick();
    check("t6_valid_rst", 32'(bus.out_valid_out), 32'd0);
    check("t6_addr_rst", 32'(bus.out_addr_out), 32'd0);
    check("t6_ch_rst", 32'(bus.out_ch_out), 32'd0);
    check("t6_wrap_rst", 32'(bus.out_wrap_out), 32'd0);
    check("t6_level_rst", 32'(bus.level_out), 32'd0);
    check("t6_empty_rst", 32'(bus.empty_out), 32'd3);
    check("t6_err_rst", 32'(bus.err_out), 32'd0);
    check("t6_ready_rst", 32'(bus.req_ready_out), 32'd0);
    rst_in = 1'b0;
    req(1'b1, 1'b0, 13'd0);
    tick();
    req(1'b0, 1'b0, 13'd0);
    check("t6_first_addr", 32'(bus.out_addr_out), 32'd0);
    check("t6_first_level", lvl(0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sonic_address_converter_mc.md
# sonic_address_converter_mc

Multi-channel, parametrised successor to the SoNIC DMA address converter. It maps per-channel word requests to physical addresses in a shared buffer RAM partitioned into `NUM_CH` equal rings of `RING_WORDS` words; `RING_WORDS` need not be a power of two. Each channel runs in one of two modes: direct (caller-supplied offset) or stream (auto-incrementing write pointer with fill-level tracking and consumer release). It sits between the chaining-DMA write engine and the buffer RAM address port.

## Interface

**Parameters**
- `ADDR_W`, default 13: request offset width and release-count width.
- `NUM_CH`, default 2: number of channels, minimum 1.
- `RING_WORDS`, default 3000: words per channel ring, 2 to 2^ADDR_W.
- `CH_W`, default max(1, clog2(NUM_CH)): channel index width.
- `PHYS_W`, default clog2(NUM_CH*RING_WORDS): physical address width.
- `LVL_W`, default clog2(RING_WORDS+1): fill-level width.

**Ports**
- `clk_in` in 1: single clock; all logic is rising-edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `cfg_mode_in` in NUM_CH: per-channel mode, 0 = direct, 1 = stream; sampled at request accept.
- `req_valid_in` in 1: request valid.
- `req_ready_out` out 1: request ready.
- `req_ch_in` in CH_W: request channel.
- `req_addr_in` in ADDR_W: word offset; direct mode only, ignored in stream mode.
- `out_valid_out` out 1: output valid.
- `out_ready_in` in 1: downstream ready.
- `out_ch_out` out CH_W: channel of the output word.
- `out_addr_out` out PHYS_W: physical address.
- `out_wrap_out` out 1: word occupies the last ring slot (local address RING_WORDS-1).
- `rel_valid_in` in 1: consumer release strobe.
- `rel_ch_in` in CH_W: release channel.
- `rel_count_in` in ADDR_W: number of words released.
- `level_out` out NUM_CH*LVL_W: per-channel fill level; channel c occupies bits [c*LVL_W +: LVL_W].
- `full_out` out NUM_CH: level == RING_WORDS.
- `empty_out` out NUM_CH: level == 0.
- `err_out` out NUM_CH: sticky error flag, per channel.

## Operation

**Accept**
- A request is accepted when `req_valid_in && req_ready_out`.
- `req_ready_out = (!out_valid_out || out_ready_in) && !(cfg_mode_in[req_ch_in] && full_out[req_ch_in])`. It depends combinationally on `req_ch_in`.
- `req_ch_in >= NUM_CH`: the request is accepted, produces no output, and leaves all state unchanged.

**Local address**
- Direct mode:
  - local = `req_addr_in`.
  - If `req_addr_in >= RING_WORDS`: the request is accepted, no output is produced, `err_out[ch]` is set, and the level is unchanged.
- Stream mode:
  - local = `wptr[ch]`.
  - `wptr[ch]` then increments; at RING_WORDS-1 it wraps to 0.
  - `level[ch]` increments.

**Physical address**
- `phys = ch*RING_WORDS + local`, computed at full PHYS_W width with no truncation.
- `out_wrap_out = (local == RING_WORDS-1)`, in both modes.

**Release**
- When `rel_valid_in` is high and `rel_ch_in < NUM_CH`: `level[rel_ch] -= rel_count_in`.
- Release applies in both modes; direct-mode levels stay 0.

**Simultaneous events**
- Stream accept and release on the same channel in the same cycle: `level_next = level + 1 - rel_count_in`.
- Underflow (`rel_count_in` greater than level plus accept): level clamps to 0 and `err_out[ch]` is set.
- Accept and release on different channels update independently.

**Other rules**
- `err_out` bits stay set until reset.
- A mode change takes effect on the next accepted request. `wptr` and `level` are not cleared by a mode change.
- `full_out`, `empty_out` and `level_out` are registered and reflect state after the last edge.

## Timing

**Latency and output register**
- Latency is 1 cycle: a request accepted at edge N gives `out_*` valid after edge N.
- Output is a single register stage:
  - `out_*` hold stable while `out_valid_out && !out_ready_in`.
  - A new accept at the same edge as a downstream take replaces the output register, giving full throughput of 1 word/cycle.
- A dropped request (error or invalid channel) clears `out_valid_out` at that edge if the register was being emptied; otherwise the register holds.

**Backpressure**
- Stream-mode backpressure: `full_out[ch]` deasserts in the cycle after a release edge. Accept is possible on the following edge.

**Reset (synchronous)**
- `out_valid_out`, `out_ch_out`, `out_addr_out`, `out_wrap_out`: 0.
- `level_out`, `full_out`, `err_out`, all `wptr`: 0.
- `empty_out`: all ones.
- `req_ready_out`: 0 while `rst_in` is high.
- Reset mid-stream discards the output register contents and all pointers and levels. The first accept after reset in stream mode maps to local 0.

## Test plan

Defaults: NUM_CH=2, RING_WORDS=3000, ADDR_W=13.

1. Direct mode, ch1, addr 100, `out_ready_in`=1 → one cycle later `out_valid_out`=1, `out_ch_out`=1, `out_addr_out`=3100, `out_wrap_out`=0; `level_out` for ch1 stays 0.
2. Stream ch0, 3000 back-to-back requests, no release →
   - addresses 0..2999 in order; `out_wrap_out`=1 only on 2999;
   - `full_out[0]`=1 and `req_ready_out`=0 for ch0, while ch1 requests are still accepted;
   - then release 10 → level 2990, `full_out[0]` clears, the next ch0 word gets address 0.
3. Stream ch1 with `out_ready_in` held low for 5 cycles → `out_addr_out` stays 3000 throughout, `req_ready_out`=0; on release it streams 3001, 3002 with no gap and no duplicate.
4. Ch0 at level 5; in one cycle, stream accept on ch0 plus release 3 on ch0 → level 3. Then release 10 → level 0, `err_out[0]`=1, `empty_out[0]`=1.
5. Direct ch1, addr 3000 → no `out_valid_out`, `err_out[1]`=1, held until reset; a following direct request to addr 2999 → 5999 with `out_wrap_out`=1.
6. Stream ch0 to level 7, then `rst_in` for 1 cycle with `out_valid_out` high → all outputs at reset values. The next ch0 stream request → address 0, level 1.
